// File: rtl/axi_handshake_throttle.sv
// Congestion injector for AXI valid/ready lanes: pass, random, periodic or block
// throttling per lane, with valid held until accepted and saturating stall counters.
module axi_handshake_throttle #(
  parameter int                NCH     = 5,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  parameter int                PROB_W  = 11,
  parameter int                CNT_W   = 16,
  parameter int                STALL_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         s_valid,
  output logic [NCH-1:0]         s_ready,
  output logic [NCH-1:0]         m_valid,
  input  logic [NCH-1:0]         m_ready,
  input  logic [2*NCH-1:0]       cfg_mode,
  input  logic [PROB_W-1:0]      cfg_prob,
  input  logic [CNT_W-1:0]       cfg_on,
  input  logic [CNT_W-1:0]       cfg_off,
  input  logic                   stall_clr,
  output logic [STALL_W*NCH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_BLOCK    = 2'd3
  } mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

  logic [CNT_W-1:0] on_last;
  logic [CNT_W-1:0] off_last;

  assign on_last  = (cfg_on == '0) ? '0 : cfg_on - CNT_W'(1);
  assign off_last = cfg_off - CNT_W'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    localparam logic [LFSR_W-1:0] SEED_X    = SEED ^ LFSR_W'(i + 1);
    localparam logic [LFSR_W-1:0] LANE_SEED = (SEED_X == '0) ? LFSR_W'(1) : SEED_X;

    mode_e              mode;
    logic               gate;
    logic               allow_q, allow_d;
    logic               held_q;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q;

    assign mode       = mode_e'(cfg_mode[2*i +: 2]);
    assign gate       = (mode == MODE_PASS) | allow_q | held_q;
    assign m_valid[i] = s_valid[i] & gate;
    assign s_ready[i] = m_ready[i] & gate;
    assign lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q + CNT_W'(1);
      allow_d = 1'b0;
      if (mode != MODE_PERIODIC) begin
        // Parked at ON/0 so that entering periodic mode always starts a fresh on-phase.
        phase_d = PH_ON;
        cnt_d   = '0;
      end else begin
        unique case (phase_q)
          PH_ON: begin
            if (cnt_q >= on_last) begin
              cnt_d = '0;
              if (cfg_off != '0) phase_d = PH_OFF;
            end
          end
          PH_OFF: begin
            if (cfg_off == '0 || cnt_q >= off_last) begin
              cnt_d   = '0;
              phase_d = PH_ON;
            end
          end
        endcase
      end

      unique case (mode)
        MODE_PASS:     allow_d = 1'b1;
        MODE_RANDOM:   allow_d = PROB_W'(lfsr_q[9:0]) < cfg_prob;
        MODE_PERIODIC: allow_d = (phase_q == PH_ON);
        MODE_BLOCK:    allow_d = 1'b0;
      endcase
    end

    // NOTE: state registers use non-blocking assignments so every lane register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        allow_q <= 1'b0;
        held_q  <= 1'b0;
        lfsr_q  <= LANE_SEED;
        phase_q <= PH_ON;
        cnt_q   <= '0;
        stall_q <= '0;
      end else begin
        allow_q <= allow_d;
        // An offered but unaccepted beat keeps the gate open until it completes.
        held_q  <= m_valid[i] & ~m_ready[i];
        lfsr_q  <= lfsr_d;
        phase_q <= phase_d;
        cnt_q   <= cnt_d;
        if (stall_clr)
          stall_q <= '0;
        else if (s_valid[i] & ~s_ready[i] & ~(&stall_q))
          stall_q <= stall_q + STALL_W'(1);
      end
    end

    assign stall_cnt[STALL_W*i +: STALL_W] = stall_q;
  end

endmodule

// File: tb/tb_axi_handshake_throttle.sv
// Scoreboard bench for axi_handshake_throttle: directed per-cycle expectations are
// queued by the stimulus and compared by an independent negedge monitor.
`timescale 1ns/1ps
module tb_axi_handshake_throttle;
  localparam int NCH = 5;
  localparam int SW  = 32;
  localparam logic [NCH-1:0] ALL  = '1;
  localparam logic [NCH-1:0] NONE = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH-1:0]    s_valid, s_ready, m_valid, m_ready;
  logic [2*NCH-1:0]  cfg_mode;
  logic [10:0]       cfg_prob;
  logic [15:0]       cfg_on, cfg_off;
  logic              stall_clr;
  logic [SW*NCH-1:0] stall_cnt;

  logic       s4_valid, s4_ready, m4_valid, m4_ready;
  logic [1:0] mode4;
  logic [3:0] stall4;

  axi_handshake_throttle #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid),
    .m_ready(m_ready), .cfg_mode(cfg_mode), .cfg_prob(cfg_prob), .cfg_on(cfg_on),
    .cfg_off(cfg_off), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  axi_handshake_throttle #(.NCH(1), .STALL_W(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s4_valid), .s_ready(s4_ready), .m_valid(m4_valid),
    .m_ready(m4_ready), .cfg_mode(mode4), .cfg_prob(cfg_prob), .cfg_on(cfg_on),
    .cfg_off(cfg_off), .stall_clr(stall_clr), .stall_cnt(stall4)
  );

  typedef struct {
    string          tag;
    logic [NCH-1:0] mv, sr, care;
    int             sl;
    logic [31:0]    sc;
    logic           c4;
    logic [3:0]     sc4;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   hs_cnt[NCH];
  int   r1[NCH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic clr_hs();
    foreach (hs_cnt[i]) hs_cnt[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input string tag, input logic [NCH-1:0] mv, input logic [NCH-1:0] sr,
                      input logic [NCH-1:0] care, input int sl, input logic [31:0] sc);
    exp_t e;
    e.tag = tag; e.mv = mv; e.sr = sr; e.care = care; e.sl = sl; e.sc = sc;
    e.c4 = 1'b0; e.sc4 = '0;
    sb.push_back(e);
    idle(1);
  endtask

  task automatic tick4(input string tag, input logic [3:0] sc4);
    exp_t e;
    e.tag = tag; e.mv = '0; e.sr = '0; e.care = '0; e.sl = -1; e.sc = '0;
    e.c4 = 1'b1; e.sc4 = sc4;
    sb.push_back(e);
    idle(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    clr_hs();
  endtask

  task automatic run_periodic(input int on, input int off, input int on_eff, input int n);
    int stalls;
    logic allowed;
    cfg_mode = {NCH{2'd2}};
    cfg_on   = 16'(on);
    cfg_off  = 16'(off);
    s_valid  = ALL;
    m_ready  = ALL;
    do_reset();
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      allowed = (k >= 1) && (((k - 1) % (on_eff + off)) < on_eff);
      tick($sformatf("periodic_%0d_%0d_c%0d", on, off, k), allowed ? ALL : NONE,
           allowed ? ALL : NONE, ALL, k % NCH, 32'(stalls));
      if (!allowed) stalls++;
    end
    check($sformatf("periodic_%0d_%0d_hs", on, off), 32'(hs_cnt[0]), 32'(n - stalls));
  endtask

  // Monitor: counts handshakes every cycle and compares any queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
        if (m_valid[i] & m_ready[i]) hs_cnt[i]++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.care != '0) begin
          check({e.tag, "/m_valid"}, 32'(m_valid & e.care), 32'(e.mv & e.care));
          check({e.tag, "/s_ready"}, 32'(s_ready & e.care), 32'(e.sr & e.care));
        end
        if (e.sl >= 0)
          check($sformatf("%s/stall%0d", e.tag, e.sl), stall_cnt[e.sl*SW +: SW], e.sc);
        if (e.c4)
          check({e.tag, "/stall4"}, 32'(stall4), 32'(e.sc4));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = '0; m_ready = '0; cfg_mode = '0; cfg_prob = '0;
    cfg_on = '0; cfg_off = '0; stall_clr = 1'b0;
    s4_valid = 1'b0; m4_ready = 1'b0; mode4 = 2'd0;
    clr_hs();
    idle(2);

    // Reset state: lane 0 pass-through, lanes 1..4 blocked.
    cfg_mode = 10'b11111111_00;
    s_valid  = ALL;
    m_ready  = ALL;
    do_reset();
    tick("reset_c0", 5'b00001, 5'b00001, ALL, 3, 0);
    tick("reset_c1", 5'b00001, 5'b00001, ALL, 3, 1);

    // Mode 0: 100 cycles of steady traffic, then mixed valid/ready patterns.
    cfg_mode = '0;
    do_reset();
    for (int k = 0; k < 100; k++) tick("pass", ALL, ALL, ALL, k % NCH, 0);
    for (int i = 0; i < NCH; i++) check($sformatf("pass_hs%0d", i), 32'(hs_cnt[i]), 100);
    s_valid = 5'b10101; m_ready = 5'b01110;
    tick("pass_mix0", 5'b10101, 5'b01110, ALL, 0, 0);
    s_valid = 5'b01010; m_ready = 5'b10011;
    tick("pass_mix1", 5'b01010, 5'b10011, ALL, 0, 1);

    // Mode 2: on/off patterns, including on=0 (one cycle) and off=0 (never off).
    run_periodic(3, 2, 3, 21);
    run_periodic(0, 1, 1, 10);
    run_periodic(2, 0, 2, 10);

    // Hold rule: lanes 0/1 offered into a stalled sink, then switched to block mode.
    cfg_on = 16'd1; cfg_off = 16'd5;
    cfg_mode = 10'b111111_10_10;
    s_valid  = 5'b00011;
    m_ready  = NONE;
    do_reset();
    tick("hold_c0", NONE, NONE, ALL, 0, 0);
    tick("hold_c1", 5'b00011, NONE, ALL, 0, 1);
    cfg_mode = '1;
    tick("hold_c2", 5'b00011, NONE, ALL, 0, 2);
    s_valid = 5'b00001;
    tick("hold_c3", 5'b00001, NONE, ALL, 0, 3);
    s_valid = 5'b00011;
    tick("hold_c4", 5'b00001, NONE, ALL, 0, 4);
    tick("hold_c5", 5'b00001, NONE, ALL, 0, 5);
    m_ready = 5'b00001;
    tick("hold_c6", 5'b00001, 5'b00001, ALL, 0, 6);
    tick("hold_c7", NONE, NONE, ALL, 0, 6);
    tick("hold_c8", NONE, NONE, ALL, 0, 7);
    tick("hold_c9", NONE, NONE, ALL, 1, 8);
    check("hold_hs0", 32'(hs_cnt[0]), 1);
    check("hold_hs1", 32'(hs_cnt[1]), 0);

    // Saturation on a 4-bit stall counter, then clear coincident with a stall.
    s_valid = NONE; m_ready = NONE; cfg_mode = '0;
    mode4 = 2'd3; s4_valid = 1'b1; m4_ready = 1'b1;
    do_reset();
    for (int k = 0; k <= 20; k++) tick4($sformatf("sat_c%0d", k), (k > 15) ? 4'd15 : 4'(k));
    stall_clr = 1'b1;
    tick4("sat_clr", 4'd15);
    stall_clr = 1'b0;
    tick4("sat_after_clr", 4'd0);
    tick4("sat_restart", 4'd1);
    s4_valid = 1'b0;

    // Mode 1 at probability one half, first run.
    cfg_mode = {NCH{2'd1}};
    cfg_prob = 11'd512;
    s_valid  = ALL;
    m_ready  = ALL;
    do_reset();
    idle(10000);
    for (int i = 0; i < NCH; i++) begin
      check_rng($sformatf("rand512_hs%0d", i), hs_cnt[i], 4700, 5300);
      r1[i] = hs_cnt[i];
    end

    // Reset while held; the random sequence must then repeat exactly.
    cfg_mode = '0;
    m_ready  = NONE;
    do_reset();
    tick("hrst_c0", ALL, NONE, ALL, 0, 0);
    tick("hrst_c1", ALL, NONE, ALL, 0, 1);
    tick("hrst_c2", ALL, NONE, ALL, 0, 2);
    cfg_mode = {NCH{2'd1}};
    rst = 1'b1;
    tick("hrst_c3", ALL, NONE, ALL, 0, 3);
    rst = 1'b0;
    m_ready = ALL;
    clr_hs();
    tick("hrst_after", NONE, NONE, ALL, 0, 0);
    idle(9999);
    for (int i = 0; i < NCH; i++) check($sformatf("rand_repeat%0d", i), 32'(hs_cnt[i]), 32'(r1[i]));

    // Probability extremes: never and always (cycle 0 has allow_q still reset).
    cfg_prob = 11'd0;
    do_reset();
    idle(2000);
    for (int i = 0; i < NCH; i++) check($sformatf("rand0_hs%0d", i), 32'(hs_cnt[i]), 0);
    cfg_prob = 11'd1024;
    do_reset();
    idle(2000);
    for (int i = 0; i < NCH; i++) check($sformatf("rand1024_hs%0d", i), 32'(hs_cnt[i]), 1999);

    idle(2);
    check("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
